sdpram_bist_ctrl: RTL and testbench

- Synthesisable built-in self-test engine for one simple dual-port RAM instance (such as playram) in a single clock domain.
- Sequence: fill the whole address space with a selectable data pattern, read it back, compare each word against the expected value, report pass/fail, error count and first failing address.
- Generalises the fixed descending-counter write/read check: parametrised widths, depth and read latency, four patterns, abort, error capture.
- Sits beside the RAM; muxed onto the RAM ports by the system when test mode is active.

---
 rtl/sdpram_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_sdpram_bist_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_bist_ctrl.sv
// sdpram_bist_ctrl: fill/readback BIST engine for one simple dual-port RAM.
// Define BIST_ERR_INJECT_EN to add inj_en/inj_addr for a single forced write error.
module sdpram_bist_ctrl #(
    parameter int ADDR_WIDTH    = 17,
    parameter int DATA_WIDTH    = 8,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     wr_clk,
    input  logic                     tb_wr_rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [1:0]               pattern_sel,
`ifdef BIST_ERR_INJECT_EN
    input  logic                     inj_en,
    input  logic [ADDR_WIDTH-1:0]    inj_addr,
`endif
    output logic                     ram_wr_en,
    output logic [ADDR_WIDTH-1:0]    ram_wr_addr,
    output logic [DATA_WIDTH-1:0]    ram_wr_data,
    output logic [ADDR_WIDTH-1:0]    ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ram_rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [63:0] CHK_64 = {32{2'b01}};
    localparam logic [DATA_WIDTH-1:0] CHK = CHK_64[DATA_WIDTH-1:0];
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LATENCY - 1);

    function automatic logic [DATA_WIDTH-1:0] pat(input logic [1:0] sel, input logic [ADDR_WIDTH-1:0] a);
        return sel == 2'd0 ? ~DATA_WIDTH'(a) :
               sel == 2'd1 ?  DATA_WIDTH'(a) :
               sel == 2'd2 ? (a[0] ? ~CHK : CHK) : '1;
    endfunction

    logic [2:0]               state_q, state_d;
    logic [1:0]               pat_q;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, rd_addr_q, ferr_q, wr_next;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic [1:0]               dr_q;
    logic [RD_LATENCY-1:0]    vld_q;
    logic [DATA_WIDTH-1:0]    exp_q   [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]    eaddr_q [RD_LATENCY];
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic                     start_ok, wr_last, rd_last, mism, flip0, flipn;

    assign start_ok = start && !abort && (state_q == S_IDLE || state_q == S_DONE);
    assign wr_last  = &wr_addr_q;
    assign rd_last  = &rd_addr_q;
    assign wr_next  = wr_addr_q + ADDR_WIDTH'(1);
    assign mism     = vld_q[RD_LATENCY-1] && ram_rd_data != exp_q[RD_LATENCY-1];

`ifdef BIST_ERR_INJECT_EN
    logic                  inj_q;
    logic [ADDR_WIDTH-1:0] inj_addr_q;
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            inj_q      <= 1'b0;
            inj_addr_q <= '0;
        end else if (start_ok) begin
            inj_q      <= inj_en;
            inj_addr_q <= inj_addr;
        end
    end
    assign flip0 = inj_en && inj_addr == '0;
    assign flipn = inj_q && inj_addr_q == wr_next;
`else
    assign flip0 = 1'b0;
    assign flipn = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_WRITE;
            S_WRITE:        if (wr_last) state_d = S_GAP;
            S_GAP:          state_d = S_READ;
            S_READ:         if (rd_last) state_d = S_DRAIN;
            S_DRAIN:        if (dr_q == DRAIN_LAST) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            dr_q      <= '0;
            vld_q     <= '0;
            err_q     <= '0;
            ferr_q    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                exp_q[i]   <= '0;
                eaddr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                pat_q     <= pattern_sel;
                wr_addr_q <= '0;
                wr_data_q <= pat(pattern_sel, '0) ^ DATA_WIDTH'(flip0);
                err_q     <= '0;
                ferr_q    <= '0;
            end
            if (state_q == S_WRITE && !wr_last && !abort) begin
                wr_addr_q <= wr_next;
                wr_data_q <= pat(pat_q, wr_next) ^ DATA_WIDTH'(flipn);
            end
            if (state_q == S_GAP && !abort) rd_addr_q <= '0;
            if (state_q == S_READ && !rd_last && !abort) rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
            dr_q       <= state_q == S_DRAIN ? dr_q + 2'd1 : 2'd0;
            // Expected word and its address travel alongside the RAM read latency.
            vld_q[0]   <= state_q == S_READ && !abort;
            exp_q[0]   <= pat(pat_q, rd_addr_q);
            eaddr_q[0] <= rd_addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1] && !abort;
                exp_q[i]   <= exp_q[i-1];
                eaddr_q[i] <= eaddr_q[i-1];
            end
            if (mism && !abort) begin
                err_q <= &err_q ? err_q : err_q + ERR_CNT_WIDTH'(1);
                if (err_q == '0) ferr_q <= eaddr_q[RD_LATENCY-1];
            end
        end
    end

    assign ram_wr_en      = state_q == S_WRITE;
    assign ram_wr_addr    = wr_addr_q;
    assign ram_wr_data    = wr_data_q;
    assign ram_rd_addr    = rd_addr_q;
    assign busy           = state_q == S_WRITE || state_q == S_GAP || state_q == S_READ || state_q == S_DRAIN;
    assign done           = state_q == S_DONE;
    assign pass           = done && err_q == '0;
    assign err_cnt        = err_q;
    assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_sdpram_bist_ctrl.sv
// tb_sdpram_bist_ctrl: two BIST instances (read latency 1 / 8-bit errors, latency 2 / 2-bit errors)
// on behavioural RAMs with selectable fault modes, checked against a pattern/readback model.
module tb_sdpram_bist_ctrl;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [1:0] psel = '0;
    logic we_a, busy_a, done_a, pass_a, we_b, busy_b, done_b, pass_b;
    logic [3:0] wa_a, ra_a, ferr_a, wa_b, ra_b, ferr_b;
    logic [7:0] wd_a, rdat_a, wd_b, rdat_b, err_a;
    logic [1:0] err_b;
    logic [7:0] mem_a [16], mem_b [16], rd_a, rd_b1, rd_b2;
    int mode = 0, ntests = 0, nfail = 0;

    always #5 clk = ~clk;

    sdpram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(1), .ERR_CNT_WIDTH(8)) ua (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start), .abort(abort), .pattern_sel(psel),
        .ram_wr_en(we_a), .ram_wr_addr(wa_a), .ram_wr_data(wd_a), .ram_rd_addr(ra_a),
        .ram_rd_data(rdat_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_cnt(err_a), .first_err_addr(ferr_a));

    sdpram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_LATENCY(2), .ERR_CNT_WIDTH(2)) ub (
        .wr_clk(clk), .tb_wr_rst(rst), .start(start), .abort(abort), .pattern_sel(psel),
        .ram_wr_en(we_b), .ram_wr_addr(wa_b), .ram_wr_data(wd_b), .ram_rd_addr(ra_b),
        .ram_rd_data(rdat_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_cnt(err_b), .first_err_addr(ferr_b));

    // Mode 1: bit 3 of cells 5 and 9 stuck at 1; mode 2: read data stuck at 0.
    always @(posedge clk) begin
        if (we_a) mem_a[wa_a] <= (mode == 1 && (wa_a == 5 || wa_a == 9)) ? (wd_a | 8'h08) : wd_a;
        if (we_b) mem_b[wa_b] <= (mode == 1 && (wa_b == 5 || wa_b == 9)) ? (wd_b | 8'h08) : wd_b;
        rd_a  <= mem_a[ra_a];
        rd_b1 <= mem_b[ra_b];
        rd_b2 <= rd_b1;
    end
    assign rdat_a = mode == 2 ? 8'h00 : rd_a;
    assign rdat_b = mode == 2 ? 8'h00 : rd_b2;

    function automatic logic [7:0] pat(input int sel, input int a);
        if (sel == 0) return 8'(255 - a);
        if (sel == 1) return 8'(a);
        if (sel == 2) return (a % 2 == 0) ? 8'h55 : 8'hAA;
        return 8'hFF;
    endfunction

    function automatic logic [7:0] readback(input int sel, input int m, input int a);
        if (m == 2) return 8'h00;
        if (m == 1 && (a == 5 || a == 9)) return pat(sel, a) | 8'h08;
        return pat(sel, a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_test(input int sel, input int m, input bit poke);
        int n = 0, first = 0, ca = -1, cb = -1, ea, eb;
        for (int a = 15; a >= 0; a--)
            if (readback(sel, m, a) != pat(sel, a)) begin n++; first = a; end
        ea = n > 255 ? 255 : n;
        eb = n > 3 ? 3 : n;
        mode = m; psel = 2'(sel); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k < 16) begin
                ntests++;
                if (we_a !== 1'b1 || wa_a !== 4'(k) || wd_a !== pat(sel, k) || wd_b !== pat(sel, k)) begin
                    nfail++;
                    $display("FAIL write k=%0d sel=%0d: en=%b addr=%0d data=%h/%h, required en=1 addr=%0d data=%h",
                             k, sel, we_a, wa_a, wd_a, wd_b, k, pat(sel, k));
                end
            end
            if (k == 16) begin
                ntests++;
                if (we_a !== 1'b0 || busy_a !== 1'b1) begin
                    nfail++;
                    $display("FAIL gap: en=%b busy=%b, required en=0 busy=1", we_a, busy_a);
                end
            end
            if (poke) psel = 2'($urandom_range(3));
            start = poke && (k == 10 || k == 25);
            if (done_a === 1'b1 && ca < 0) ca = k;
            if (done_b === 1'b1 && cb < 0) cb = k;
            if (k < 59) step();
        end
        start = 1'b0;
        ntests++;
        if (ca != 34 || cb != 35) begin
            nfail++;
            $display("FAIL done_time sel=%0d: got %0d/%0d, required 34/35", sel, ca, cb);
        end
        ntests++;
        if (done_a !== 1'b1 || done_b !== 1'b1 || busy_a !== 1'b0 || ra_a !== 4'd15) begin
            nfail++;
            $display("FAIL done_hold: done=%b/%b busy=%b rd_addr=%0d, required 1/1 0 15", done_a, done_b, busy_a, ra_a);
        end
        ntests++;
        if (err_a !== 8'(ea) || err_b !== 2'(eb)) begin
            nfail++;
            $display("FAIL err_cnt sel=%0d mode=%0d: got %0d/%0d, required %0d/%0d", sel, m, err_a, err_b, ea, eb);
        end
        ntests++;
        if (ferr_a !== 4'(first) || ferr_b !== 4'(first)) begin
            nfail++;
            $display("FAIL first_err sel=%0d mode=%0d: got %0d/%0d, required %0d", sel, m, ferr_a, ferr_b, first);
        end
        ntests++;
        if (pass_a !== (n == 0) || pass_b !== (n == 0)) begin
            nfail++;
            $display("FAIL pass sel=%0d mode=%0d: got %b/%b, required %b", sel, m, pass_a, pass_b, n == 0);
        end
    endtask

    task automatic test_reset();
        step();
        step();
        ntests++;
        if ({we_a, busy_a, done_a, pass_a, err_a, ferr_a, wa_a, wd_a, ra_a} !== '0) begin
            nfail++;
            $display("FAIL reset_a: got %h, required 0", {we_a, busy_a, done_a, pass_a, err_a, ferr_a, wa_a, wd_a, ra_a});
        end
        ntests++;
        if ({we_b, busy_b, done_b, pass_b, err_b, ferr_b, wa_b, wd_b, ra_b} !== '0) begin
            nfail++;
            $display("FAIL reset_b: got %h, required 0", {we_b, busy_b, done_b, pass_b, err_b, ferr_b, wa_b, wd_b, ra_b});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_patterns();
        run_test(0, 0, 0);
        run_test(2, 0, 0);
        run_test(3, 1, 0);
        run_test(1, 1, 0);
        run_test(0, 1, 0);
        run_test(3, 2, 0);
        for (int r = 0; r < 4; r++)
            run_test(int'($urandom_range(3)), int'($urandom_range(2)), 1'($urandom_range(1)));
    endtask

    task automatic test_abort();
        psel = 2'd1; mode = 0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 7; k++) step();
        ntests++;
        if (we_a !== 1'b1 || wa_a !== 4'd7) begin
            nfail++;
            $display("FAIL abort_setup: en=%b addr=%0d, required 1 7", we_a, wa_a);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        ntests++;
        if (we_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || we_b !== 1'b0 || busy_b !== 1'b0) begin
            nfail++;
            $display("FAIL abort_write: en=%b busy=%b done=%b en_b=%b busy_b=%b, required all 0",
                     we_a, busy_a, done_a, we_b, busy_b);
        end
        step();
        step();
        ntests++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            nfail++;
            $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy_a, done_a);
        end
        run_test(1, 1, 0);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        ntests++;
        if (done_a !== 1'b0 || we_a !== 1'b0 || busy_a !== 1'b0 || err_a !== 8'd1 || err_b !== 2'd1) begin
            nfail++;
            $display("FAIL abort_start: done=%b en=%b busy=%b err=%0d/%0d, required 0 0 0 1/1",
                     done_a, we_a, busy_a, err_a, err_b);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        psel = 2'd0; mode = 0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        ntests++;
        if (busy_a !== 1'b1 || we_a !== 1'b0) begin
            nfail++;
            $display("FAIL read_setup: busy=%b en=%b, required 1 0", busy_a, we_a);
        end
        #1 rst = 1'b1;
        #1;
        ntests++;
        if ({we_a, busy_a, done_a, pass_a, err_a, ferr_a, wa_a, wd_a, ra_a} !== '0 ||
            {we_b, busy_b, done_b, err_b, ra_b} !== '0) begin
            nfail++;
            $display("FAIL async_reset: got %h/%h, required 0", {we_a, busy_a, done_a, pass_a, err_a, ferr_a, wa_a, wd_a, ra_a},
                     {we_b, busy_b, done_b, err_b, ra_b});
        end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_start_busy();
        run_test(2, 0, 1);
        run_test(0, 2, 1);
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_abort();
        test_reset_mid_read();
        test_start_busy();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
